// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among NUM_REQ byte-stream requesters.
// Whole packets are granted round-robin; each byte is handed to uart_tx with a
// one-cycle start pulse, and the next byte waits for uart_tx's done pulse.
// A granted lane that leaves the link idle for MAX_STALL LOAD cycles loses the grant.
//
// Optional feature macro: UART_ARB_TAG_EN -- prefix every packet with a tag byte
// {TAG_PREFIX, grant index}.
//
// Ports:
//   clk_in, rst_in   clock, synchronous active-high reset
//   req_valid_in     per-lane byte valid
//   req_data_in      per-lane byte, lane i = [8i+7:8i]
//   req_last_in      per-lane end-of-packet flag
//   req_ready_out    one-hot accept pulse (combinational with LOAD)
//   grant_out        one-hot current owner, zero when idle
//   busy_out         state is not IDLE
//   tx_start_out     start pulse to uart_tx
//   tx_data_out      byte to uart_tx, held between starts
//   tx_done_in       end-of-frame pulse from uart_tx
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_STALL  = 1024,
  parameter logic [3:0]  TAG_PREFIX = 4'hA
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [NUM_REQ-1:0]   req_valid_in,
  input  logic [NUM_REQ*8-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]   req_last_in,
  output logic [NUM_REQ-1:0]   req_ready_out,
  output logic [NUM_REQ-1:0]   grant_out,
  output logic                 busy_out,
  output logic                 tx_start_out,
  output logic [7:0]           tx_data_out,
  input  logic                 tx_done_in
);

  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned STALL_W = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TAG,
    S_LOAD,
    S_WAIT_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic                 last_q, last_d;
  logic [7:0]           txd_q, txd_d;

  logic [NUM_REQ-1:0]   rot_c;
  logic [IDX_W:0]       sum_c;
  logic                 pick_found_c;
  logic [IDX_W-1:0]     pick_idx_c;
  logic [7:0]           lane_data_c;
  logic                 lane_valid_c;
  logic                 lane_last_c;
  logic [IDX_W-1:0]     ptr_next_c;
  logic [STALL_W-1:0]   stall_inc_c;
  logic                 start_c;
  logic [NUM_REQ-1:0]   ready_c;
  logic [7:0]           data_c;

`ifndef UART_ARB_TAG_EN
  logic unused_tag_prefix_c;
  assign unused_tag_prefix_c = ^TAG_PREFIX;
`endif

  // Round-robin pick: rotate valids so bit k is lane (ptr+k) mod NUM_REQ.
  always_comb begin
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    sum_c        = '0;
    rot_c        = NUM_REQ'({req_valid_in, req_valid_in} >> ptr_q);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found_c && rot_c[k]) begin
        pick_found_c = 1'b1;
        sum_c        = {1'b0, ptr_q} + (IDX_W+1)'(k);
        if (sum_c >= (IDX_W+1)'(NUM_REQ)) begin
          sum_c = sum_c - (IDX_W+1)'(NUM_REQ);
        end
        pick_idx_c = IDX_W'(sum_c);
      end
    end
  end

  // Granted lane views and helper arithmetic.
  assign lane_data_c  = req_data_in[{gidx_q, 3'b000} +: 8];
  assign lane_valid_c = req_valid_in[gidx_q];
  assign lane_last_c  = req_last_in[gidx_q];
  assign ptr_next_c   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
  // Saturating stall counter increment.
  assign stall_inc_c  = (stall_q == STALL_W'(MAX_STALL)) ? stall_q : stall_q + STALL_W'(1);

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    stall_d = stall_q;
    last_d  = last_q;
    txd_d   = txd_q;
    start_c = 1'b0;
    ready_c = '0;
    data_c  = txd_q;

    case (state_q)
      S_IDLE: begin
        if (pick_found_c) begin
          gidx_d  = pick_idx_c;
          grant_d = NUM_REQ'(1) << pick_idx_c;
          stall_d = '0;
`ifdef UART_ARB_TAG_EN
          state_d = S_TAG;
`else
          state_d = S_LOAD;
`endif
        end
      end

`ifdef UART_ARB_TAG_EN
      S_TAG: begin
        start_c = 1'b1;
        data_c  = {TAG_PREFIX, 4'(gidx_q)};
        txd_d   = data_c;
        last_d  = 1'b0;
        state_d = S_WAIT_DONE;
      end
`endif

      S_LOAD: begin
        if (lane_valid_c) begin
          start_c = 1'b1;
          ready_c = NUM_REQ'(1) << gidx_q;
          data_c  = lane_data_c;
          txd_d   = lane_data_c;
          last_d  = lane_last_c;
          stall_d = '0;
          state_d = S_WAIT_DONE;
        end else begin
          stall_d = stall_inc_c;
          // Stalled too long: drop the packet and move the pointer on.
          if (stall_inc_c == STALL_W'(MAX_STALL)) begin
            state_d = S_IDLE;
            grant_d = '0;
            ptr_d   = ptr_next_c;
          end
        end
      end

      S_WAIT_DONE: begin
        if (tx_done_in) begin
          if (last_q) begin
            state_d = S_IDLE;
            grant_d = '0;
            ptr_d   = ptr_next_c;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      stall_q <= '0;
      last_q  <= 1'b0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      last_q  <= last_d;
      txd_q   <= txd_d;
    end
  end

  assign req_ready_out = ready_c;
  assign grant_out     = grant_q;
  assign busy_out      = (state_q != S_IDLE);
  assign tx_start_out  = start_c;
  assign tx_data_out   = data_c;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based requesters, a uart_tx stand-in that
// answers each start with done 34 cycles later, and directed/table checks.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned MS = 16;
`ifdef UART_ARB_TAG_EN
  localparam int TAG = 1;
`else
  localparam int TAG = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_in;
  logic [N-1:0]   req_valid_in;
  logic [N*8-1:0] req_data_in;
  logic [N-1:0]   req_last_in;
  logic [N-1:0]   req_ready_out;
  logic [N-1:0]   grant_out;
  logic           busy_out;
  logic           tx_start_out;
  logic [7:0]     tx_data_out;
  logic           tx_done_in;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_STALL(MS), .TAG_PREFIX(4'hA)) dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_data_in   (req_data_in),
    .req_last_in   (req_last_in),
    .req_ready_out (req_ready_out),
    .grant_out     (grant_out),
    .busy_out      (busy_out),
    .tx_start_out  (tx_start_out),
    .tx_data_out   (tx_data_out),
    .tx_done_in    (tx_done_in)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } lb_t;

  typedef struct {
    logic [3:0] mask;
    int         n;
    int         ord [4];
  } vec_t;

  lb_t        lane_q [N][$];
  logic [7:0] exp_d [$];
  logic [N-1:0] exp_r [$];

  // Monitor: cycle stamp, start log, ready capture, uart_tx done countdown.
  int           mcyc = 0;
  int           ucnt = 0;
  logic [N-1:0] ready_seen = '0;
  logic [7:0]   st_d [$];
  logic [N-1:0] st_r [$];
  int           st_c [$];

  always @(negedge clk) begin
    mcyc++;
    if (ucnt > 0) ucnt--;
    ready_seen = req_ready_out;
    if (tx_start_out) begin
      st_d.push_back(tx_data_out);
      st_r.push_back(req_ready_out);
      st_c.push_back(mcyc);
      ucnt = 34;
    end
  end

  int   checks = 0;
  int   errors = 0;
  logic man_pulse = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (lane_q[i].size() > 0) begin
        req_valid_in[i]       = 1'b1;
        req_data_in[8*i +: 8] = lane_q[i][0].d;
        req_last_in[i]        = lane_q[i][0].l;
      end else begin
        req_valid_in[i]       = 1'b0;
        req_data_in[8*i +: 8] = 8'h00;
        req_last_in[i]        = 1'b0;
      end
    end
  endtask

  // One clock: consume accepted bytes, drive lanes and done, settle to negedge+1.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ready_seen[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
    end
    drive();
    tx_done_in = (ucnt == 1) || man_pulse;
    man_pulse  = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic step_to(input int c);
    while (mcyc < c) step();
  endtask

  task automatic push_b(input int lane, input logic [7:0] d, input logic l);
    lb_t b;
    b.d = d;
    b.l = l;
    lane_q[lane].push_back(b);
  endtask

  function automatic bit lanes_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < N; i++) if (lane_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(busy_out == 1'b0 && lanes_empty() && ucnt == 0) && n < 3000) begin
      step();
      n++;
    end
    chk($sformatf("%s idle_reached", name), 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_start(input string name, input logic [7:0] x, output int s);
    int n;
    n = 0;
    s = 0;
    while (!(tx_start_out && tx_data_out == x) && n < 3000) begin
      step();
      n++;
    end
    s = mcyc;
    chk($sformatf("%s start_seen", name), 32'(n < 3000), 32'd1);
  endtask

  task automatic exp_byte(input int lane, input logic [7:0] d, input bit first);
    if (TAG != 0 && first) begin
      exp_d.push_back({4'hA, 4'(lane)});
      exp_r.push_back('0);
    end
    exp_d.push_back(d);
    exp_r.push_back(N'(1) << lane);
  endtask

  task automatic check_stream(input string name, input int base);
    chk($sformatf("%s count", name), 32'(st_d.size() - base), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      if (base + i < st_d.size()) begin
        chk($sformatf("%s data%0d", name, i), 32'(st_d[base+i]), 32'(exp_d[i]));
        chk($sformatf("%s ready%0d", name, i), 32'(st_r[base+i]), 32'(exp_r[i]));
      end
    end
    exp_d.delete();
    exp_r.delete();
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", mcyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [7];
    int   base;
    int   s;
    int   cnt;
    logic [7:0] d0;

    vt[0] = '{4'b1001, 2, '{3, 0, 0, 0}};
    vt[1] = '{4'b1111, 4, '{1, 2, 3, 0}};
    vt[2] = '{4'b0101, 2, '{2, 0, 0, 0}};
    vt[3] = '{4'b1000, 1, '{3, 0, 0, 0}};
    vt[4] = '{4'b1010, 2, '{1, 3, 0, 0}};
    vt[5] = '{4'b0001, 1, '{0, 0, 0, 0}};
    vt[6] = '{4'b0110, 2, '{1, 2, 0, 0}};

    rst_in       = 1'b1;
    req_valid_in = '0;
    req_data_in  = '0;
    req_last_in  = '0;
    tx_done_in   = 1'b0;
    step();
    step();
    chk("rst grant", 32'(grant_out), 32'd0);
    chk("rst busy", 32'(busy_out), 32'd0);
    chk("rst start", 32'(tx_start_out), 32'd0);
    chk("rst ready", 32'(req_ready_out), 32'd0);
    chk("rst data", 32'(tx_data_out), 32'd0);
    rst_in = 1'b0;
    step();

    // Lane 0 three-byte packet: latency, hold, spacing, release.
    base = st_d.size();
    push_b(0, 8'h24, 1'b0);
    push_b(0, 8'h55, 1'b0);
    push_b(0, 8'h7E, 1'b1);
    step();
    chk("t1 idle grant", 32'(grant_out), 32'd0);
    chk("t1 idle start", 32'(tx_start_out), 32'd0);
    step();
    d0 = (TAG != 0) ? 8'hA0 : 8'h24;
    chk("t1 grant", 32'(grant_out), 32'b0001);
    chk("t1 start", 32'(tx_start_out), 32'd1);
    chk("t1 data", 32'(tx_data_out), 32'(d0));
    chk("t1 ready", 32'(req_ready_out), (TAG != 0) ? 32'd0 : 32'b0001);
    step();
    step();
    chk("t1 hold data", 32'(tx_data_out), 32'(d0));
    chk("t1 hold start", 32'(tx_start_out), 32'd0);
    chk("t1 hold ready", 32'(req_ready_out), 32'd0);
    wait_idle("t1");
    chk("t1 grant released", 32'(grant_out), 32'd0);
    if (st_d.size() >= base + TAG + 3) begin
      chk("t1 gap1", 32'(st_c[base+TAG+1] - st_c[base+TAG]), 32'd35);
      chk("t1 gap2", 32'(st_c[base+TAG+2] - st_c[base+TAG+1]), 32'd35);
    end
    exp_byte(0, 8'h24, 1'b1);
    exp_byte(0, 8'h55, 1'b0);
    exp_byte(0, 8'h7E, 1'b0);
    check_stream("t1", base);

    // Lanes 1 and 2 together from pointer 0: whole packets, no interleave.
    do_reset();
    base = st_d.size();
    push_b(1, 8'h11, 1'b0);
    push_b(1, 8'h12, 1'b1);
    push_b(2, 8'h21, 1'b0);
    push_b(2, 8'h22, 1'b1);
    wait_idle("t2");
    exp_byte(1, 8'h11, 1'b1);
    exp_byte(1, 8'h12, 1'b0);
    exp_byte(2, 8'h21, 1'b1);
    exp_byte(2, 8'h22, 1'b0);
    check_stream("t2", base);

    // Round-robin order table (pointer carries across vectors).
    for (int v = 0; v < 7; v++) begin
      base = st_d.size();
      for (int i = 0; i < N; i++) begin
        if (vt[v].mask[i]) push_b(i, 8'(16 * (v + 1) + i), 1'b1);
      end
      wait_idle($sformatf("rr%0d", v));
      for (int k = 0; k < vt[v].n; k++) begin
        exp_byte(vt[v].ord[k], 8'(16 * (v + 1) + vt[v].ord[k]), 1'b1);
      end
      check_stream($sformatf("rr%0d", v), base);
    end

    // Stall: lane 3 stops mid-packet, grant revoked after MS LOAD cycles, lane 0 next.
    base = st_d.size();
    push_b(3, 8'h33, 1'b0);
    push_b(0, 8'h0A, 1'b1);
    wait_start("t3", 8'h33, s);
    step_to(s + 35);
    chk("t3 load grant", 32'(grant_out), 32'b1000);
    chk("t3 load busy", 32'(busy_out), 32'd1);
    step_to(s + 50);
    chk("t3 last stall grant", 32'(grant_out), 32'b1000);
    chk("t3 last stall start", 32'(tx_start_out), 32'd0);
    step();
    chk("t3 revoked grant", 32'(grant_out), 32'd0);
    chk("t3 revoked busy", 32'(busy_out), 32'd0);
    step();
    chk("t3 next grant", 32'(grant_out), 32'b0001);
    chk("t3 next start", 32'(tx_start_out), 32'd1);
    chk("t3 next data", 32'(tx_data_out), (TAG != 0) ? 32'hA0 : 32'h0A);
    wait_idle("t3");
    exp_byte(3, 8'h33, 1'b1);
    exp_byte(0, 8'h0A, 1'b1);
    check_stream("t3", base);

    // Stray done while IDLE and while LOAD.
    cnt = st_d.size();
    man_pulse = 1'b1;
    step();
    step();
    chk("t5 idle busy", 32'(busy_out), 32'd0);
    chk("t5 idle nostart", 32'(st_d.size()), 32'(cnt));
    push_b(2, 8'h2B, 1'b0);
    wait_start("t5", 8'h2B, s);
    cnt = st_d.size();
    step_to(s + 37);
    man_pulse = 1'b1;
    step();
    step();
    chk("t5 load grant", 32'(grant_out), 32'b0100);
    chk("t5 load busy", 32'(busy_out), 32'd1);
    chk("t5 load nostart", 32'(st_d.size()), 32'(cnt));
    step_to(s + 50);
    chk("t5 stall grant", 32'(grant_out), 32'b0100);
    step();
    chk("t5 revoked grant", 32'(grant_out), 32'd0);
    chk("t5 nostart", 32'(st_d.size()), 32'(cnt));
    wait_idle("t5");

    // Reset during WAIT_DONE of byte 2 of 4, late done ignored, pointer back to 0.
    push_b(1, 8'h41, 1'b0);
    push_b(1, 8'h42, 1'b0);
    push_b(1, 8'h43, 1'b0);
    push_b(1, 8'h44, 1'b1);
    wait_start("t4", 8'h42, s);
    cnt = st_d.size();
    step_to(s + 5);
    rst_in = 1'b1;
    lane_q[1].delete();
    step();
    chk("t4 rst grant", 32'(grant_out), 32'd0);
    chk("t4 rst busy", 32'(busy_out), 32'd0);
    chk("t4 rst start", 32'(tx_start_out), 32'd0);
    chk("t4 rst ready", 32'(req_ready_out), 32'd0);
    chk("t4 rst data", 32'(tx_data_out), 32'd0);
    rst_in = 1'b0;
    step_to(s + 34);
    chk("t4 late done busy", 32'(busy_out), 32'd0);
    step();
    step();
    chk("t4 after done busy", 32'(busy_out), 32'd0);
    chk("t4 after done nostart", 32'(st_d.size()), 32'(cnt));
    base = st_d.size();
    push_b(0, 8'h0C, 1'b1);
    push_b(3, 8'h3C, 1'b1);
    wait_idle("t4");
    exp_byte(0, 8'h0C, 1'b1);
    exp_byte(3, 8'h3C, 1'b1);
    check_stream("t4", base);

`ifdef UART_ARB_TAG_EN
    // Tagged single-byte packet from lane 2.
    base = st_d.size();
    push_b(2, 8'h01, 1'b1);
    wait_idle("t6");
    exp_byte(2, 8'h01, 1'b1);
    check_stream("t6", base);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
